// File: rtl/alu_issue_if.sv
// Instruction handshake plus the operand/result bus between the issue stage and the ALU.
// The issue stage takes the slave side; the instruction source and the ALU take the master side.
interface alu_issue_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [3:0]  alu_opcode;
    logic        alu_ar_flag;
    logic [15:0] alu_src1;
    logic [15:0] alu_src2;
    logic        alu_out_en;
    logic [15:0] alu_out;
    logic [3:0]  alu_flags;

    modport master (
        output instr_valid, instr, alu_out, alu_flags,
        input  instr_ready, alu_opcode, alu_ar_flag, alu_src1, alu_src2, alu_out_en
    );

    modport slave (
        input  instr_valid, instr, alu_out, alu_flags,
        output instr_ready, alu_opcode, alu_ar_flag, alu_src1, alu_src2, alu_out_en
    );
endinterface

// File: rtl/alu_issue.sv
// Issue/writeback stage in front of the ALU: decodes 16-bit instructions against a 4 x 16
// register file, drives the ALU for ALU_LAT cycles, then writes the result and latches flags.
module alu_issue #(
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    alu_issue_if.slave   bus,
    output logic [3:0]   flags,
    output logic         done,
    output logic         err,
    input  logic [1:0]   dbg_sel,
    output logic [15:0]  dbg_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WB    = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam logic [3:0] OP_LDI = 4'b0001;
    localparam logic [3:0] OP_MOV = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0110;

    localparam logic [1:0] LAT_LAST = 2'(ALU_LAT - 1);

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= 4'b0011) && (op <= 4'b1011);
    endfunction

    function automatic logic is_illegal_op(input logic [3:0] op);
        return op >= 4'b1100;
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  next_s;
    logic [1:0]  cnt_r;
    logic [15:0] regs_r [4];
    logic [1:0]  rd_r;
    logic        fin_wr_r;
    logic [15:0] fin_data_r;
    logic        ready_r;
    logic        done_r;
    logic        err_r;
    logic [3:0]  flags_r;
    logic [3:0]  opcode_r;
    logic        ar_r;
    logic [15:0] src1_r;
    logic [15:0] src2_r;
    logic        out_en_r;

    logic [3:0]  op_s;
    logic [1:0]  rd_s;
    logic [1:0]  rs_s;
    logic [15:0] src2_s;
    logic        accept_s;
    logic        reject_s;
    logic        issue_s;

    // Field decode of the instruction currently offered; operands come straight from the file.
    always_comb begin
        op_s     = bus.instr[15:12];
        rd_s     = bus.instr[11:10];
        rs_s     = bus.instr[9:8];
        src2_s   = 16'd0;
        if (bus.instr[6]) begin
            src2_s = {10'd0, bus.instr[5:0]};
        end else begin
            src2_s = regs_r[rs_s];
        end
        accept_s = bus.instr_valid & ready_r;
        reject_s = is_illegal_op(op_s) | ((op_s == OP_DIV) & (src2_s == 16'd0));
        issue_s  = is_alu_op(op_s) & ~reject_s;
    end

    // Next-state selection.
    always_comb begin
        next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_s = issue_s ? ST_ISSUE : ST_FIN;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cnt_r == LAT_LAST) begin
                    next_s = ST_WB;
                end else begin
                    next_s = ST_ISSUE;
                end
            end
            ST_WB:   next_s = ST_IDLE;
            ST_FIN:  next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // State, latency counter and the registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 2'd0;
            ready_r  <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            out_en_r <= 1'b0;
        end else begin
            state_r  <= next_s;
            cnt_r    <= (state_r == ST_ISSUE && next_s == ST_ISSUE) ? cnt_r + 2'd1 : 2'd0;
            ready_r  <= (next_s == ST_IDLE);
            out_en_r <= (next_s == ST_ISSUE) || (next_s == ST_WB);
            done_r   <= (next_s == ST_WB) ||
                        ((state_r == ST_IDLE) && accept_s && !issue_s && !reject_s);
            err_r    <= (state_r == ST_IDLE) && accept_s && reject_s;
        end
    end

    // Per-instruction capture at accept: destination, pending direct write, ALU operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_r       <= 2'd0;
            fin_wr_r   <= 1'b0;
            fin_data_r <= 16'd0;
            opcode_r   <= 4'd0;
            ar_r       <= 1'b0;
            src1_r     <= 16'd0;
            src2_r     <= 16'd0;
        end else if (state_r == ST_IDLE && accept_s) begin
            rd_r       <= rd_s;
            fin_wr_r   <= ((op_s == OP_LDI) || (op_s == OP_MOV)) && !reject_s;
            fin_data_r <= (op_s == OP_LDI) ? {8'd0, bus.instr[7:0]} : regs_r[rs_s];
            if (issue_s) begin
                opcode_r <= op_s;
                ar_r     <= bus.instr[7];
                src1_r   <= regs_r[rd_s];
                src2_r   <= src2_s;
            end
        end
    end

    // Single write port: ALU result in WB, LDI/MOV data in FIN; flags only from WB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= 16'd0;
            end
            flags_r <= 4'd0;
        end else if (state_r == ST_WB) begin
            regs_r[rd_r] <= bus.alu_out;
            flags_r      <= bus.alu_flags;
        end else if (state_r == ST_FIN && fin_wr_r) begin
            regs_r[rd_r] <= fin_data_r;
        end
    end

    assign bus.instr_ready = ready_r;
    assign bus.alu_opcode  = opcode_r;
    assign bus.alu_ar_flag = ar_r;
    assign bus.alu_src1    = src1_r;
    assign bus.alu_src2    = src2_r;
    assign bus.alu_out_en  = out_en_r;
    assign flags           = flags_r;
    assign done            = done_r;
    assign err             = err_r;
    assign dbg_data        = regs_r[dbg_sel];

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: two instances (ALU_LAT 1 and 3) behind a behavioural ALU, with a
// register-file model and a scoreboard of expected completions.
module tb_alu_issue;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct {
        logic        is_err;
        logic        wr;
        logic [1:0]  rd;
        logic [15:0] val;
        logic        upd;
        logic [3:0]  flg;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_d   [2];
    logic        valid_d [2];
    logic [15:0] instr_d [2];
    logic [1:0]  sel_d   [2];
    logic        ready_w [2];
    logic        oe_w    [2];
    logic [3:0]  op_w    [2];
    logic        ar_w    [2];
    logic [15:0] s1_w    [2];
    logic [15:0] s2_w    [2];
    logic [3:0]  flags_w [2];
    logic        done_w  [2];
    logic        err_w   [2];
    logic [15:0] dbg_w   [2];

    logic [15:0] rm [2][4];
    logic [3:0]  fm [2];

    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic ar,
                                          input logic [15:0] a, input logic [15:0] b);
        logic [3:0] sh;
        sh = b[3:0];
        case (op)
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd5:    return a * b;
            4'd6:    return (b == 16'd0) ? 16'hFFFF : a / b;
            4'd7:    return a & b;
            4'd8:    return a | b;
            4'd9:    return a ^ b;
            4'd10:   return ar ? ((a << sh) | (a >> (5'd16 - {1'b0, sh}))) : (a << sh);
            4'd11:   return ar ? ((a >> sh) | (a << (5'd16 - {1'b0, sh}))) : (a >> sh);
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [3:0] flg_f(input logic [15:0] v);
        return {^v, v[0], v[15], (v == 16'd0)};
    endfunction

    alu_issue_if ifa ();
    alu_issue_if ifb ();

    assign ifa.instr_valid = valid_d[0];
    assign ifa.instr       = instr_d[0];
    assign ifa.alu_out     = ifa.alu_out_en ?
                             alu_f(ifa.alu_opcode, ifa.alu_ar_flag, ifa.alu_src1, ifa.alu_src2) : 16'hBAD0;
    assign ifa.alu_flags   = ifa.alu_out_en ? flg_f(ifa.alu_out) : 4'hF;
    assign ready_w[0] = ifa.instr_ready;
    assign oe_w[0]    = ifa.alu_out_en;
    assign op_w[0]    = ifa.alu_opcode;
    assign ar_w[0]    = ifa.alu_ar_flag;
    assign s1_w[0]    = ifa.alu_src1;
    assign s2_w[0]    = ifa.alu_src2;

    assign ifb.instr_valid = valid_d[1];
    assign ifb.instr       = instr_d[1];
    assign ifb.alu_out     = ifb.alu_out_en ?
                             alu_f(ifb.alu_opcode, ifb.alu_ar_flag, ifb.alu_src1, ifb.alu_src2) : 16'hBAD0;
    assign ifb.alu_flags   = ifb.alu_out_en ? flg_f(ifb.alu_out) : 4'hF;
    assign ready_w[1] = ifb.instr_ready;
    assign oe_w[1]    = ifb.alu_out_en;
    assign op_w[1]    = ifb.alu_opcode;
    assign ar_w[1]    = ifb.alu_ar_flag;
    assign s1_w[1]    = ifb.alu_src1;
    assign s2_w[1]    = ifb.alu_src2;

    alu_issue #(.ALU_LAT(LAT_A)) dut_a (
        .clk(clk), .rst(rst_d[0]), .bus(ifa), .flags(flags_w[0]), .done(done_w[0]),
        .err(err_w[0]), .dbg_sel(sel_d[0]), .dbg_data(dbg_w[0])
    );

    alu_issue #(.ALU_LAT(LAT_B)) dut_b (
        .clk(clk), .rst(rst_d[1]), .bus(ifb), .flags(flags_w[1]), .done(done_w[1]),
        .err(err_w[1]), .dbg_sel(sel_d[1]), .dbg_data(dbg_w[1])
    );

    function automatic exp_t predict(input int d, input logic [15:0] ins);
        exp_t e;
        logic [3:0]  op;
        logic [1:0]  rd;
        logic [1:0]  rs;
        logic [15:0] s2;
        op = ins[15:12];
        rd = ins[11:10];
        rs = ins[9:8];
        s2 = ins[6] ? {10'd0, ins[5:0]} : rm[d][rs];
        e.is_err = 1'b0;
        e.wr     = 1'b0;
        e.rd     = rd;
        e.val    = 16'd0;
        e.upd    = 1'b0;
        e.flg    = fm[d];
        e.lat    = 0;
        if (op >= 4'd12 || (op == 4'd6 && s2 == 16'd0)) begin
            e.is_err = 1'b1;
        end else if (op == 4'd1) begin
            e.wr  = 1'b1;
            e.val = {8'd0, ins[7:0]};
        end else if (op == 4'd2) begin
            e.wr  = 1'b1;
            e.val = rm[d][rs];
        end else if (op >= 4'd3) begin
            e.wr  = 1'b1;
            e.val = alu_f(op, ins[7], rm[d][rd], s2);
            e.upd = 1'b1;
            e.flg = flg_f(e.val);
            e.lat = (d == 0) ? LAT_A : LAT_B;
        end
        return e;
    endfunction

    // Offer one instruction, push its expectation, return at the first falling edge after accept.
    task automatic send(input int d, input logic [15:0] ins);
        int n;
        sb.push_back(predict(d, ins));
        @(negedge clk);
        valid_d[d] = 1'b1;
        instr_d[d] = ins;
        n = 0;
        while (ready_w[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL accept_timeout dut%0d ready=%b required 1", d, ready_w[d]);
        end
        @(posedge clk);
        @(negedge clk);
        valid_d[d] = 1'b0;
        instr_d[d] = 16'($urandom);
    endtask

    // Wait for the completion pulse and compare it against the oldest scoreboard entry.
    task automatic finish(input int d);
        exp_t e;
        int   k;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty dut%0d size=0 required >0", d);
            return;
        end
        e = sb.pop_front();
        k = 0;
        while (done_w[d] !== 1'b1 && err_w[d] !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != e.lat) begin
            errors++;
            $display("FAIL latency dut%0d got %0d edges required %0d", d, k, e.lat);
        end
        checks++;
        if ({done_w[d], err_w[d]} !== {~e.is_err, e.is_err}) begin
            errors++;
            $display("FAIL pulse_kind dut%0d done/err=%b%b required %b%b",
                     d, done_w[d], err_w[d], ~e.is_err, e.is_err);
        end
        checks++;
        if (oe_w[d] !== e.upd || ready_w[d] !== 1'b0) begin
            errors++;
            $display("FAIL busy_outputs dut%0d out_en=%b ready=%b required %b 0", d, oe_w[d], ready_w[d], e.upd);
        end
        @(negedge clk);
        if (e.wr) rm[d][e.rd] = e.val;
        if (e.upd) fm[d] = e.flg;
        checks++;
        if (done_w[d] !== 1'b0 || err_w[d] !== 1'b0 || ready_w[d] !== 1'b1 || oe_w[d] !== 1'b0) begin
            errors++;
            $display("FAIL after_pulse dut%0d done=%b err=%b ready=%b out_en=%b required 0 0 1 0",
                     d, done_w[d], err_w[d], ready_w[d], oe_w[d]);
        end
        checks++;
        if (flags_w[d] !== fm[d]) begin
            errors++;
            $display("FAIL flags dut%0d got %h required %h", d, flags_w[d], fm[d]);
        end
        for (int r = 0; r < 4; r++) begin
            sel_d[d] = 2'(r);
            #1;
            checks++;
            if (dbg_w[d] !== rm[d][r]) begin
                errors++;
                $display("FAIL regfile dut%0d R%0d got %h required %h", d, r, dbg_w[d], rm[d][r]);
            end
        end
    endtask

    task automatic check_cleared(input int d, input string tag);
        checks++;
        if ({ready_w[d], done_w[d], err_w[d], oe_w[d], ar_w[d]} !== 5'd0 ||
            {op_w[d], s1_w[d], s2_w[d], flags_w[d]} !== 40'd0) begin
            errors++;
            $display("FAIL %s dut%0d rdy/done/err/oe/ar=%b%b%b%b%b op=%h s1=%h s2=%h fl=%h required all 0",
                     tag, d, ready_w[d], done_w[d], err_w[d], oe_w[d], ar_w[d], op_w[d], s1_w[d], s2_w[d], flags_w[d]);
        end
        for (int r = 0; r < 4; r++) begin
            sel_d[d] = 2'(r);
            #1;
            checks++;
            if (dbg_w[d] !== 16'd0) begin
                errors++;
                $display("FAIL %s_reg dut%0d R%0d got %h required 0", tag, d, r, dbg_w[d]);
            end
        end
        for (int r = 0; r < 4; r++) rm[d][r] = 16'd0;
        fm[d] = 4'd0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst_d[d] = 1'b0; valid_d[d] = 1'b0; instr_d[d] = 16'd0; sel_d[d] = 2'd0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) check_cleared(d, "reset_values");
        @(negedge clk);
        rst_d[0] = 1'b1;
        rst_d[1] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ready_w[d] !== 1'b0) begin
                errors++;
                $display("FAIL ready_before_edge dut%0d got %b required 0", d, ready_w[d]);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ready_w[d] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_release dut%0d got %b required 1", d, ready_w[d]);
            end
        end
    endtask

    task automatic test_add();
        send(0, 16'h100A); finish(0);
        send(0, 16'h1405); finish(0);
        send(0, 16'h3100);
        checks++;
        if (s1_w[0] !== 16'd10 || s2_w[0] !== 16'd5 || op_w[0] !== 4'b0011 || oe_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL add_drive src1=%0d src2=%0d op=%b oe=%b required 10 5 0011 1",
                     s1_w[0], s2_w[0], op_w[0], oe_w[0]);
        end
        finish(0);
        checks++;
        if (rm[0][0] !== 16'd15) begin
            errors++;
            $display("FAIL add_result model R0=%0d required 15", rm[0][0]);
        end
    endtask

    task automatic test_imm_sub();
        send(0, 16'h4445);
        checks++;
        if (s1_w[0] !== 16'd5 || s2_w[0] !== 16'd5 || op_w[0] !== 4'b0100) begin
            errors++;
            $display("FAIL sub_drive src1=%0d src2=%0d op=%b required 5 5 0100", s1_w[0], s2_w[0], op_w[0]);
        end
        finish(0);
        checks++;
        if (flags_w[0] !== 4'b0001) begin
            errors++;
            $display("FAIL sub_zero_flags got %b required 0001", flags_w[0]);
        end
    endtask

    task automatic test_div_zero();
        send(0, 16'h6200);
        checks++;
        if (oe_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL div0_out_en got %b required 0", oe_w[0]);
        end
        finish(0);
    endtask

    task automatic test_illegal_busy();
        send(1, 16'hF123); finish(1);
        send(1, 16'h18F1); finish(1);
        sb.push_back(predict(1, 16'hA8CC));
        @(negedge clk);
        valid_d[1] = 1'b1;
        instr_d[1] = 16'hA8CC;
        @(posedge clk);
        @(negedge clk);
        instr_d[1] = 16'h1C5A;
        checks++;
        if (ar_w[1] !== 1'b1 || op_w[1] !== 4'b1010 || oe_w[1] !== 1'b1 || ready_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL rol_drive ar=%b op=%b oe=%b ready=%b required 1 1010 1 0",
                     ar_w[1], op_w[1], oe_w[1], ready_w[1]);
        end
        finish(1);
        checks++;
        if (rm[1][2] !== 16'h100F) begin
            errors++;
            $display("FAIL rol_result model R2=%h required 100F", rm[1][2]);
        end
        sb.push_back(predict(1, 16'h1C5A));
        @(posedge clk);
        @(negedge clk);
        valid_d[1] = 1'b0;
        finish(1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] fixed [5];
        fixed = '{16'h2C00, 16'h0000, 16'h3500, 16'h5141, 16'hB0C3};
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 5; i++) begin
                send(d, fixed[i]);
                finish(d);
            end
            for (int i = 0; i < 24; i++) begin
                send(d, 16'($urandom));
                finish(d);
            end
        end
    endtask

    task automatic test_midop_reset();
        int seen;
        send(1, 16'h1007); finish(1);
        send(1, 16'h3000);
        void'(sb.pop_back());
        @(negedge clk);
        rst_d[1] = 1'b0;
        #1;
        check_cleared(1, "reset_in_issue");
        @(negedge clk);
        rst_d[1] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready_w[1] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_issue_reset got %b required 1", ready_w[1]);
        end

        send(0, 16'h1403); finish(0);
        send(0, 16'h3500);
        void'(sb.pop_back());
        @(negedge clk);
        rst_d[0] = 1'b0;
        #1;
        check_cleared(0, "reset_in_wb");
        @(negedge clk);
        rst_d[0] = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_w[0] === 1'b1 || err_w[0] === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || ready_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL wb_reset_discard pulses=%0d ready=%b required 0 1", seen, ready_w[0]);
        end
        sel_d[0] = 2'd1;
        #1;
        checks++;
        if (dbg_w[0] !== 16'd0) begin
            errors++;
            $display("FAIL wb_reset_nowrite R1 got %h required 0", dbg_w[0]);
        end
        send(0, 16'h1833); finish(0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_imm_sub();
        test_div_zero();
        test_illegal_busy();
        test_back_to_back();
        test_midop_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
